// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg: shared state type and width helper for the Karatsuba multipliers.
package karatsuba_pkg;
    typedef enum logic [2:0] {IDLE, MUL_H, MUL_L, MUL_M, COMB, DONE} kseq_state_t;

    function automatic int kara_half(input int n);
        return n / 2;
    endfunction
endpackage

// File: rtl/karatsuba.sv
// karatsuba: combinational recursive Karatsuba multiplier, 2N-bit unsigned product of two N-bit operands.
module karatsuba
    import karatsuba_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);
    generate
        if (N <= 4) begin : g_leaf
            assign p_o = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};
        end else begin : g_rec
            localparam int H = kara_half(N);
            logic [H:0]   da, db;
            logic [H-1:0] ma, mb;
            logic [N-1:0] p1, p2, p3;
            logic [N+1:0] mid;
            assign da = {1'b0, a_i[H-1:0]} - {1'b0, a_i[N-1:H]};
            assign db = {1'b0, b_i[N-1:H]} - {1'b0, b_i[H-1:0]};
            assign ma = H'(da[H] ? -da : da);
            assign mb = H'(db[H] ? -db : db);
            karatsuba #(.N(H)) u_h (.a_i(a_i[N-1:H]), .b_i(b_i[N-1:H]), .p_o(p3));
            karatsuba #(.N(H)) u_l (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(p2));
            karatsuba #(.N(H)) u_m (.a_i(ma), .b_i(mb), .p_o(p1));
            // mid = a_h*b_l + a_l*b_h, so it is never negative
            assign mid = (da[H] ^ db[H]) ? {2'b0, p3} + {2'b0, p2} - {2'b0, p1}
                                         : {2'b0, p3} + {2'b0, p2} + {2'b0, p1};
            assign p_o = {p3, p2} + ((2 * N)'(mid) << H);
        end
    endgenerate
endmodule

// File: rtl/karatsuba_seq.sv
// karatsuba_seq: handshaked sequential Karatsuba multiplier reusing one half-width
// combinational multiplier over three cycles for the three sub-products.
module karatsuba_seq
    import karatsuba_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] c,
    output logic           busy
);
    localparam int H = kara_half(N);

    kseq_state_t    state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [N-1:0]   p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, prod;
    logic           neg_q, neg_d;
    logic [2*N-1:0] c_q, c_d;
    logic [H:0]     da, db;
    logic [H-1:0]   mag_a, mag_b, ma, mb;
    logic [N+1:0]   mid;

    assign da    = {1'b0, a_q[H-1:0]} - {1'b0, a_q[N-1:H]};
    assign db    = {1'b0, b_q[N-1:H]} - {1'b0, b_q[H-1:0]};
    assign mag_a = H'(da[H] ? -da : da);
    assign mag_b = H'(db[H] ? -db : db);

    // shared multiplier operands, steered by state; idle states feed zero
    assign ma = state_q == MUL_H ? a_q[N-1:H] :
                state_q == MUL_L ? a_q[H-1:0] :
                state_q == MUL_M ? mag_a : '0;
    assign mb = state_q == MUL_H ? b_q[N-1:H] :
                state_q == MUL_L ? b_q[H-1:0] :
                state_q == MUL_M ? mag_b : '0;

    karatsuba #(.N(H)) u_mul (.a_i(ma), .b_i(mb), .p_o(prod));

    assign mid = neg_q ? {2'b0, p3_q} + {2'b0, p2_q} - {2'b0, p1_q}
                       : {2'b0, p3_q} + {2'b0, p2_q} + {2'b0, p1_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        p3_d    = p3_q;
        neg_d   = neg_q;
        c_d     = c_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                state_d = MUL_H;
            end
            MUL_H: begin
                p3_d    = prod;
                state_d = MUL_L;
            end
            MUL_L: begin
                p2_d    = prod;
                state_d = MUL_M;
            end
            MUL_M: begin
                p1_d    = prod;
                neg_d   = da[H] ^ db[H];
                state_d = COMB;
            end
            COMB: begin
                c_d     = {p3_q, p2_q} + ((2 * N)'(mid) << H);
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            neg_q   <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            neg_q   <= neg_d;
            c_q     <= c_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = state_q == DONE;
    assign c         = c_q;
endmodule

// File: tb/tb_karatsuba_seq.sv
// tb_karatsuba_seq: directed and randomised checks of the N=8 sequential Karatsuba multiplier.
module tb_karatsuba_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] c;
    int          vectors = 0;
    int          miscompares = 0;

    karatsuba_seq #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e, input string tag);
        int n;
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
        wait_valid(n);
        check({tag, " latency"}, 32'(n), 32'd4);
        check({tag, " product"}, 32'(c), 32'(e));
        step();
        check({tag, " released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int  n;
        bit  ok;
        logic [7:0] x, y;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #3;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset c", 32'(c), 32'd0);
        #5 rst_n = 1'b1;
        step();

        run_op(8'hFF, 8'hFF, 16'hFE01, "ffxff");
        run_op(8'h1F, 8'h2F, 16'h05B1, "neg_mid");
        run_op(8'h00, 8'hAB, 16'h0000, "zero");

        // backpressure: result must hold with in_ready low
        a = 8'h0F; b = 8'hF0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wait_valid(n);
        check("bp latency", 32'(n), 32'd4);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            ok &= (c == 16'h0E10) && out_valid && !in_ready;
        end
        check("bp hold", 32'(ok), 32'd1);
        check("bp product", 32'(c), 32'h0E10);

        // in_valid held high across two operand pairs
        out_ready = 1'b1; in_valid = 1'b1; a = 8'h03; b = 8'h05;
        step();
        check("bp handshake out_valid", 32'(out_valid), 32'd0);
        check("bp handshake in_ready", 32'(in_ready), 32'd1);
        step();
        check("bp reaccept busy", 32'(busy), 32'd1);
        a = 8'h07; b = 8'h09;
        wait_valid(n);
        check("hold1 latency", 32'(n), 32'd4);
        check("hold1 product", 32'(c), 32'h000F);
        step();
        check("hold1 done in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("hold2 busy", 32'(busy), 32'd1);
        wait_valid(n);
        check("hold2 latency", 32'(n), 32'd4);
        check("hold2 product", 32'(c), 32'h003F);
        step();
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ok &= !busy && !out_valid;
            step();
        end
        check("no third result", 32'(ok), 32'd1);

        // asynchronous reset while in MUL_L
        a = 8'h55; b = 8'h66; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst c", 32'(c), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        step();
        run_op(8'h10, 8'h10, 16'h0100, "post_rst");

        // random operands with random consumer stalls
        for (int i = 0; i < 300; i++) begin
            x = 8'($urandom); y = 8'($urandom);
            a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
            step();
            in_valid = 1'b0;
            wait_valid(n);
            repeat ($urandom_range(0, 3)) step();
            check("rand product", 32'(c), 32'(16'(x) * 16'(y)));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            if (out_valid || !in_ready) check("rand handshake", 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
